// File: rtl/controller.sv
// VeriRISC instruction sequencer: 8-phase counter plus halt flag, decoded into datapath strobes.
// Optional feature: define CTRL_RESUME_EN to add a resume input that leaves the halted state.
module controller #(
  parameter int unsigned OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
`ifdef CTRL_RESUME_EN
  input  logic           resume,
`endif
  output logic [2:0]     phase,
  output logic           sel,
  output logic           rd,
  output logic           ld_ir,
  output logic           halt,
  output logic           inc_pc,
  output logic           ld_ac,
  output logic           ld_pc,
  output logic           wr,
  output logic           data_e
);

  localparam logic [2:0] INST_ADDR  = 3'd0;
  localparam logic [2:0] INST_FETCH = 3'd1;
  localparam logic [2:0] INST_LOAD  = 3'd2;
  localparam logic [2:0] IDLE       = 3'd3;
  localparam logic [2:0] OP_ADDR    = 3'd4;
  localparam logic [2:0] OP_FETCH   = 3'd5;
  localparam logic [2:0] ALU_OP     = 3'd6;
  localparam logic [2:0] STORE      = 3'd7;

  localparam logic [OPW-1:0] OP_HLT = OPW'(0);
  localparam logic [OPW-1:0] OP_SKZ = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_AND = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4);
  localparam logic [OPW-1:0] OP_LDA = OPW'(5);
  localparam logic [OPW-1:0] OP_STO = OPW'(6);
  localparam logic [OPW-1:0] OP_JMP = OPW'(7);

  logic [2:0] phase_q, phase_d;
  logic       halted_q, halted_d;
  logic       resume_req;

  logic is_hlt, is_skz, is_sto, is_jmp, alu_op;

`ifdef CTRL_RESUME_EN
  assign resume_req = resume;
`else
  assign resume_req = 1'b0;
`endif

  assign is_hlt = (opcode == OP_HLT);
  assign is_skz = (opcode == OP_SKZ);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);
  assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);

  // Halt freezes the counter at OP_ADDR; only reset (or resume) restarts at INST_ADDR.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (halted_q) begin
      if (resume_req) begin
        halted_d = 1'b0;
        phase_d  = INST_ADDR;
      end
    end else if (phase_q == OP_ADDR && is_hlt) begin
      halted_d = 1'b1;
    end else begin
      phase_d = phase_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  assign phase = phase_q;

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    halt   = 1'b0;
    inc_pc = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      unique case (phase_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          halt   = is_hlt;
          inc_pc = !is_hlt;
        end
        OP_FETCH: begin
          rd = alu_op;
        end
        ALU_OP: begin
          rd     = alu_op;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        default: ;
      endcase
    end
  end

  // Structural invariants of the decode; not present in synthesis netlists.
  a_wr_rd_excl : assert property (@(posedge clk) disable iff (rst) !(wr && rd));
  a_pc_excl    : assert property (@(posedge clk) disable iff (rst) !(ld_pc && inc_pc));

endmodule

// File: doc/controller.md
# controller

Instruction sequencer for the VeriRISC datapath. Owns the 3-bit phase counter and decodes the current phase, opcode and accumulator-zero flag into the load, read, write and select strobes. Those strobes drive the instruction register, accumulator, program counter, address mux and memory. This block initiates every register `load` in the datapath; the registers are the responders.

## Interface
Parameters:
- `OPW`, 3: opcode width. Fixed encoding below; other values are unsupported.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `opcode` input OPW: current instruction opcode from the IR output. HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- `zero` input 1: accumulator-is-zero flag.
- `resume` input 1: exit the halted state. Present only with `CTRL_RESUME_EN`.
- `phase` output 3: current phase; debug and bench visibility.
- `sel` output 1: address mux select; 1 = PC, 0 = IR operand.
- `rd` output 1: memory read enable.
- `ld_ir` output 1: IR load.
- `halt` output 1: processor halted.
- `inc_pc` output 1: PC increment.
- `ld_ac` output 1: accumulator load.
- `ld_pc` output 1: PC load (jump).
- `wr` output 1: memory write strobe.
- `data_e` output 1: accumulator-to-data-bus drive enable.

## Operation
- State: 3-bit `phase` register plus a 1-bit `halted` flag. Phases in order:
  - 0 INST_ADDR
  - 1 INST_FETCH
  - 2 INST_LOAD
  - 3 IDLE
  - 4 OP_ADDR
  - 5 OP_FETCH
  - 6 ALU_OP
  - 7 STORE
- Phase transitions: `phase` increments by 1 each clock, wrapping 7 -> 0. It holds while `halted`=1.
- Entering halt: at phase 4 with opcode=HLT, the next edge sets `halted`=1 and `phase` stays at 4. Only `rst` clears the halted state (or `resume`, see Configuration).
- ALUOP is shorthand for opcode ∈ {ADD, AND, XOR, LDA}.
- Outputs are a combinational decode of the registered `phase`, registered `halted`, `opcode` and `zero`. All strobes not listed for a phase are 0.
  - Phase 0: sel=1.
  - Phase 1: sel=1, rd=1.
  - Phase 2: sel=1, rd=1, ld_ir=1.
  - Phase 3: sel=1, rd=1, ld_ir=1.
  - Phase 4: halt = (opcode==HLT); inc_pc = (opcode!=HLT).
  - Phase 5: rd = ALUOP.
  - Phase 6: rd = ALUOP; inc_pc = (opcode==SKZ && zero); ld_pc = (opcode==JMP); data_e = (opcode==STO).
  - Phase 7: rd = ALUOP; ld_ac = ALUOP; ld_pc = (opcode==JMP); wr = (opcode==STO); data_e = (opcode==STO).
- While `halted`=1: halt=1 and all other strobes are 0, regardless of opcode.
- Mutual exclusion: `wr` and `rd` are never both 1. `ld_pc` and `inc_pc` are never both 1.

## Timing
- Reset: on a rising edge with `rst`=1, `phase`<=0 and `halted`<=0.
  - Outputs after reset: phase=0, sel=1, all other strobes 0.
  - `rst` wins over halt entry and over `resume` on the same edge.
  - `rst` mid-instruction abandons that instruction; no strobe from the abandoned phase survives past the edge.
- Instruction latency: 8 clocks per instruction (phase 0 through 7).
- Output timing: strobes are valid one combinational delay after the edge that sets `phase`. Datapath registers sample them on the following edge.
- `opcode` must be stable from phase 4 through phase 7. It is ignored in phases 0-3; the IR is loading during phases 2-3.
- `zero` is sampled only in phase 6.
- SKZ with zero=1 produces two increments: one in phase 4 and one in phase 6. This skips the next instruction.

## Configuration
- `CTRL_RESUME_EN` defined:
  - The `resume` port exists.
  - With `halted`=1 and `resume`=1 at an edge, `halted`<=0 and `phase`<=0.
  - `halt` deasserts the cycle after that edge; execution restarts at INST_ADDR.
  - `resume` has no effect when `halted`=0.
- `CTRL_RESUME_EN` undefined:
  - No `resume` port.
  - Halt is left only by `rst`.

## Test plan
- Reset and counting: assert `rst` one cycle, then run 9 clocks with opcode=ADD, zero=0.
  - `phase` reads 0,1,...,7,0.
  - sel=1 only in phases 0-3; ld_ir=1 only in phases 2-3.
  - ld_ac=1 only in phase 7.
- STO: opcode=6.
  - Phase 6: data_e=1, wr=0.
  - Phase 7: data_e=1, wr=1, rd=0, ld_ac=0.
- SKZ: opcode=1.
  - With zero=1: inc_pc=1 in phase 4 and phase 6.
  - With zero=0: inc_pc=1 in phase 4 only.
- JMP: opcode=7.
  - ld_pc=1 in phases 6 and 7.
  - inc_pc=1 only in phase 4; rd=0 in phases 5-7.
- HLT: opcode=0.
  - halt=1 at phase 4; phase stays 4 for 10+ clocks with all other strobes 0.
  - Apply `rst`: next cycle phase=0, halt=0.
  - With `CTRL_RESUME_EN`: pulsing resume=1 gives phase=0, halt=0 the next cycle.
- Reset mid-instruction: assert `rst` during phase 6 with opcode=SKZ, zero=1.
  - Next cycle: phase=0, inc_pc=0, sel=1.
